combo_lock_ctrl: RTL

Sequencing controller for the 6-digit combination lock datapath. It accepts one-cycle digit strobes from the switch/key front end and compares them against a stored, reprogrammable BCD code. It counts failed attempts and enforces a timed lockout. Registered mode outputs drive the HEX display mux (digit / CLOSED / OPEn / lockout).

---
 rtl/combo_lock_ctrl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/combo_lock_ctrl.sv
// Sequencing controller for a multi-digit BCD combination lock.
// Checks strobed digits against a reprogrammable stored code.
// Counts consecutive failed attempts and enforces a timed lockout.
// All outputs come from registers only (Moore).
module combo_lock_ctrl #(
    parameter int                      NUM_DIGITS     = 6,
    parameter int                      MAX_FAIL       = 3,
    parameter int                      LOCKOUT_CYCLES = 16,
    parameter logic [4*NUM_DIGITS-1:0] DEFAULT_CODE   = 24'h722297
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        digit_strobe,
    input  logic [3:0]  digit,
    input  logic        relock_req,
    input  logic        prog_req,
    output logic [1:0]  mode,
    output logic        prog_active,
    output logic [2:0]  digit_cnt,
    output logic [3:0]  fail_cnt,
    output logic [15:0] lockout_left
);

    localparam int              CW          = 4 * NUM_DIGITS;
    localparam logic [2:0]      LAST_IDX    = 3'(NUM_DIGITS - 1);
    localparam logic [3:0]      MAX_FAIL_C  = 4'(MAX_FAIL);
    localparam logic [15:0]     LOCKOUT_C   = 16'(LOCKOUT_CYCLES);

    typedef enum logic [2:0] {
        ST_ENTER,
        ST_CLOSED,
        ST_OPEN,
        ST_PROG,
        ST_LOCKOUT
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  code_q, code_d;
    logic [CW-1:0]  shadow_q, shadow_d;
    logic [2:0]     digit_cnt_q, digit_cnt_d;
    logic [3:0]     fail_cnt_q, fail_cnt_d;
    logic [15:0]    lockout_left_q, lockout_left_d;
    logic           mismatch_q, mismatch_d;

    logic [CW-1:0]  code_shift;
    logic [3:0]     expected_nib;
    logic           digit_bad;
    logic           digit_wrong;
    logic           last_digit;
    logic [CW-1:0]  shadow_next;

    // Compare helpers: the expected nibble for the current position, MSB first.
    always_comb begin
        code_shift   = code_q >> (4 * (LAST_IDX - digit_cnt_q));
        expected_nib = code_shift[3:0];
        digit_bad    = (digit > 4'd9);
        digit_wrong  = digit_bad || (digit != expected_nib);
        last_digit   = (digit_cnt_q == LAST_IDX);
        shadow_next  = {shadow_q[CW-5:0], digit};
    end

    // Next-state logic for the lock sequencer and all of its counters.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves one unassigned (no latches).
        state_d        = state_q;
        code_d         = code_q;
        shadow_d       = shadow_q;
        digit_cnt_d    = digit_cnt_q;
        fail_cnt_d     = fail_cnt_q;
        lockout_left_d = lockout_left_q;
        mismatch_d     = mismatch_q;

        unique case (state_q)
            ST_ENTER: begin
                if (relock_req) begin
                    // Restart the entry; the failure history is kept.
                    digit_cnt_d = 3'd0;
                    mismatch_d  = 1'b0;
                end else if (digit_strobe) begin
                    if (last_digit) begin
                        digit_cnt_d = 3'd0;
                        mismatch_d  = 1'b0;
                        if (!(mismatch_q || digit_wrong)) begin
                            state_d    = ST_OPEN;
                            fail_cnt_d = 4'd0;
                        end else if (fail_cnt_q + 4'd1 == MAX_FAIL_C) begin
                            state_d        = ST_LOCKOUT;
                            fail_cnt_d     = MAX_FAIL_C;
                            lockout_left_d = LOCKOUT_C;
                        end else begin
                            state_d    = ST_CLOSED;
                            fail_cnt_d = fail_cnt_q + 4'd1;
                        end
                    end else begin
                        digit_cnt_d = digit_cnt_q + 3'd1;
                        mismatch_d  = mismatch_q | digit_wrong;
                    end
                end
            end

            ST_CLOSED: begin
                if (relock_req) begin
                    state_d     = ST_ENTER;
                    digit_cnt_d = 3'd0;
                    mismatch_d  = 1'b0;
                end
            end

            ST_OPEN: begin
                // Relock has priority over a simultaneous programming request.
                if (relock_req) begin
                    state_d     = ST_ENTER;
                    digit_cnt_d = 3'd0;
                    mismatch_d  = 1'b0;
                end else if (prog_req) begin
                    state_d     = ST_PROG;
                    digit_cnt_d = 3'd0;
                end
            end

            ST_PROG: begin
                if (relock_req) begin
                    // Abort without touching the stored code; any strobe is dropped.
                    state_d     = ST_ENTER;
                    digit_cnt_d = 3'd0;
                    mismatch_d  = 1'b0;
                end else if (digit_strobe) begin
                    if (digit_bad) begin
                        state_d     = ST_OPEN;
                        digit_cnt_d = 3'd0;
                    end else if (last_digit) begin
                        code_d      = shadow_next;
                        shadow_d    = shadow_next;
                        state_d     = ST_ENTER;
                        digit_cnt_d = 3'd0;
                        mismatch_d  = 1'b0;
                    end else begin
                        shadow_d    = shadow_next;
                        digit_cnt_d = digit_cnt_q + 3'd1;
                    end
                end
            end

            ST_LOCKOUT: begin
                if (lockout_left_q == 16'd1) begin
                    state_d        = ST_ENTER;
                    fail_cnt_d     = 4'd0;
                    lockout_left_d = 16'd0;
                    digit_cnt_d    = 3'd0;
                    mismatch_d     = 1'b0;
                end else begin
                    lockout_left_d = lockout_left_q - 16'd1;
                end
            end

            default: begin
                state_d = ST_ENTER;
            end
        endcase
    end

    // State and datapath registers with synchronous reset; the code reverts to its default.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (rst) begin
            state_q        <= ST_ENTER;
            code_q         <= DEFAULT_CODE;
            shadow_q       <= '0;
            digit_cnt_q    <= 3'd0;
            fail_cnt_q     <= 4'd0;
            lockout_left_q <= 16'd0;
            mismatch_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            code_q         <= code_d;
            shadow_q       <= shadow_d;
            digit_cnt_q    <= digit_cnt_d;
            fail_cnt_q     <= fail_cnt_d;
            lockout_left_q <= lockout_left_d;
            mismatch_q     <= mismatch_d;
        end
    end

    // Display mode decoded purely from the registered state.
    always_comb begin
        mode = 2'b00;
        unique case (state_q)
            ST_CLOSED:  mode = 2'b01;
            ST_OPEN:    mode = 2'b10;
            ST_LOCKOUT: mode = 2'b11;
            default:    mode = 2'b00;
        endcase
    end

    assign prog_active  = (state_q == ST_PROG);
    assign digit_cnt    = digit_cnt_q;
    assign fail_cnt     = fail_cnt_q;
    assign lockout_left = lockout_left_q;

endmodule
